input_debouncer: RTL and testbench

//   Conditions raw board inputs (16 slide switches, 4 push buttons) before the

---
 rtl/input_debouncer.sv | 122 ++++++++++++
 tb/tb_input_debouncer.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/input_debouncer.sv
// ---------------------------------------------------------------------------
// input_debouncer
//   Conditions raw board inputs (slide switches and push buttons) before the
//   gpio peripheral reads them. Every channel is synchronized into clk, then
//   filtered by a per-channel stability counter. A new level is accepted only
//   after it has differed from the current stable value for DEBOUNCE_CYCLES
//   consecutive cycles. Registered edge pulses follow one cycle behind the
//   stable levels.
//
// Parameters
//   N_SW            number of switch channels
//   N_BTN           number of push-button channels
//   SYNC_STAGES     synchronizer depth, 2..4
//   DEBOUNCE_CYCLES mismatched cycles required to accept a change, >= 1
//   CNT_W           counter width, 2**CNT_W > DEBOUNCE_CYCLES-1
//
// Ports
//   clk         system clock
//   rst_n       asynchronous active-low reset (already conditioned upstream)
//   pin_sw_i    raw switch pins, asynchronous to clk
//   pin_btn_i   raw button pins, active high, asynchronous to clk
//   sw_o        debounced switch levels
//   btn_o       debounced button levels
//   btn_rise_o  one-cycle pulse when btn_o[i] goes 0->1
//   btn_fall_o  one-cycle pulse when btn_o[i] goes 1->0
//   sw_chg_o    one-cycle pulse when any sw_o bit changes
// ---------------------------------------------------------------------------
module input_debouncer #(
  parameter int N_SW            = 16,
  parameter int N_BTN           = 4,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int CNT_W           = 20
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_SW-1:0]  pin_sw_i,
  input  logic [N_BTN-1:0] pin_btn_i,
  output logic [N_SW-1:0]  sw_o,
  output logic [N_BTN-1:0] btn_o,
  output logic [N_BTN-1:0] btn_rise_o,
  output logic [N_BTN-1:0] btn_fall_o,
  output logic             sw_chg_o
);

  localparam int N_CH = N_SW + N_BTN;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [N_CH-1:0]  w_ch;
  logic [N_CH-1:0]  w_sync;
  logic [N_CH-1:0]  r_sync [SYNC_STAGES];
  logic [CNT_W-1:0] r_cnt  [N_CH];
  logic [N_CH-1:0]  r_stable;
  logic [N_CH-1:0]  r_stable_d;
  logic [N_BTN-1:0] r_btn_rise;
  logic [N_BTN-1:0] r_btn_fall;
  logic             r_sw_chg;

  // Buttons occupy the upper channels, switches the lower ones.
  assign w_ch   = {pin_btn_i, pin_sw_i};
  assign w_sync = r_sync[SYNC_STAGES-1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < SYNC_STAGES; k++) begin
        r_sync[k] <= '0;
      end
    end else begin
      r_sync[0] <= w_ch;
      for (int k = 1; k < SYNC_STAGES; k++) begin
        r_sync[k] <= r_sync[k-1];
      end
    end
  end

  // Any cycle where the synchronized input agrees with the stable value
  // discards the partial count, so short glitches leave no trace. The counter
  // stops at CNT_MAX because reaching it always commits the new level.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stable <= '0;
      for (int i = 0; i < N_CH; i++) begin
        r_cnt[i] <= '0;
      end
    end else begin
      for (int i = 0; i < N_CH; i++) begin
        if (w_sync[i] == r_stable[i]) begin
          r_cnt[i] <= '0;
        end else if (r_cnt[i] == CNT_MAX) begin
          r_stable[i] <= w_sync[i];
          r_cnt[i]    <= '0;
        end else begin
          r_cnt[i] <= r_cnt[i] + CNT_W'(1);
        end
      end
    end
  end

  // Pulses compare stable against its one-cycle-old copy and are registered,
  // so they appear the cycle after the level output changes. Both copies
  // clear together on reset, hence reset itself never produces a pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stable_d <= '0;
      r_btn_rise <= '0;
      r_btn_fall <= '0;
      r_sw_chg   <= 1'b0;
    end else begin
      r_stable_d <= r_stable;
      r_btn_rise <= r_stable[N_CH-1:N_SW] & ~r_stable_d[N_CH-1:N_SW];
      r_btn_fall <= ~r_stable[N_CH-1:N_SW] & r_stable_d[N_CH-1:N_SW];
      r_sw_chg   <= |(r_stable[N_SW-1:0] ^ r_stable_d[N_SW-1:0]);
    end
  end

  assign sw_o       = r_stable[N_SW-1:0];
  assign btn_o      = r_stable[N_CH-1:N_SW];
  assign btn_rise_o = r_btn_rise;
  assign btn_fall_o = r_btn_fall;
  assign sw_chg_o   = r_sw_chg;

endmodule

// File: tb/tb_input_debouncer.sv
// ---------------------------------------------------------------------------
// tb_input_debouncer
//   Directed bench for input_debouncer with DEBOUNCE_CYCLES=8, SYNC_STAGES=2,
//   so a held input change shows on the level outputs 10 edges after the
//   first sampling edge and on the pulse outputs one edge later.
// ---------------------------------------------------------------------------
module tb_input_debouncer;

  logic        clk;
  logic        rst_n;
  logic [15:0] pin_sw_i;
  logic [3:0]  pin_btn_i;
  logic [15:0] sw_o;
  logic [3:0]  btn_o;
  logic [3:0]  btn_rise_o;
  logic [3:0]  btn_fall_o;
  logic        sw_chg_o;

  int n_checks = 0;
  int n_errors = 0;
  int cnt_rise [4];
  int cnt_fall [4];
  int cnt_chg;

  input_debouncer #(
    .N_SW(16), .N_BTN(4), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(8), .CNT_W(20)
  ) dut (
    .clk(clk), .rst_n(rst_n), .pin_sw_i(pin_sw_i), .pin_btn_i(pin_btn_i),
    .sw_o(sw_o), .btn_o(btn_o), .btn_rise_o(btn_rise_o),
    .btn_fall_o(btn_fall_o), .sw_chg_o(sw_chg_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clear_counts();
    for (int b = 0; b < 4; b++) begin
      cnt_rise[b] = 0;
      cnt_fall[b] = 0;
    end
    cnt_chg = 0;
  endtask

  // Advance n edges, sampling 1 ns after each edge and tallying pulses.
  task automatic run(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
      for (int b = 0; b < 4; b++) begin
        if (btn_rise_o[b]) cnt_rise[b]++;
        if (btn_fall_o[b]) cnt_fall[b]++;
      end
      if (sw_chg_o) cnt_chg++;
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_sw"},   32'(sw_o), 32'h0);
    check({tag, "_btn"},  32'(btn_o), 32'h0);
    check({tag, "_rise"}, 32'(btn_rise_o), 32'h0);
    check({tag, "_fall"}, 32'(btn_fall_o), 32'h0);
    check({tag, "_chg"},  32'(sw_chg_o), 32'h0);
  endtask

  task automatic reset_to_zero();
    pin_sw_i  = '0;
    pin_btn_i = '0;
    rst_n     = 1'b0;
    run(3);
    rst_n = 1'b1;
    run(3);
  endtask

  initial begin
    rst_n     = 1'b0;
    pin_sw_i  = 16'hFFFF;
    pin_btn_i = 4'hF;
    clear_counts();

    // 1: reset with inputs high, then release
    #1;
    check_all_zero("t1_in_reset_a");
    run(3);
    check_all_zero("t1_in_reset_b");
    rst_n = 1'b1;
    clear_counts();
    run(9);
    check("t1_sw_edge9",  32'(sw_o), 32'h0);
    check("t1_btn_edge9", 32'(btn_o), 32'h0);
    run(1);
    check("t1_sw_edge10",   32'(sw_o), 32'hFFFF);
    check("t1_btn_edge10",  32'(btn_o), 32'hF);
    check("t1_rise_edge10", 32'(btn_rise_o), 32'h0);
    run(1);
    check("t1_rise_edge11", 32'(btn_rise_o), 32'hF);
    check("t1_chg_edge11",  32'(sw_chg_o), 32'h1);
    run(3);
    check("t1_rise_after", 32'(btn_rise_o), 32'h0);
    check("t1_chg_count",  32'(cnt_chg), 32'd1);
    for (int b = 0; b < 4; b++) check($sformatf("t1_rise_count%0d", b), 32'(cnt_rise[b]), 32'd1);

    // 2a: 7-cycle glitch is rejected
    reset_to_zero();
    clear_counts();
    pin_btn_i[0] = 1'b1;
    run(7);
    pin_btn_i[0] = 1'b0;
    run(20);
    check("t2a_btn",        32'(btn_o), 32'h0);
    check("t2a_rise_count", 32'(cnt_rise[0]), 32'd0);

    // 2b: 8-cycle pulse is accepted
    clear_counts();
    pin_btn_i[0] = 1'b1;
    run(8);
    pin_btn_i[0] = 1'b0;
    run(1);
    check("t2b_btn_edge9",  32'(btn_o), 32'h0);
    run(1);
    check("t2b_btn_edge10", 32'(btn_o), 32'h1);
    run(1);
    check("t2b_rise_edge11", 32'(btn_rise_o), 32'h1);
    run(25);
    check("t2b_btn_end",        32'(btn_o), 32'h0);
    check("t2b_rise_count",     32'(cnt_rise[0]), 32'd1);
    check("t2b_fall_count",     32'(cnt_fall[0]), 32'd1);

    // 3: bouncing switch settles high
    clear_counts();
    for (int t = 0; t < 39; t++) begin
      if (t % 3 == 0) pin_sw_i[5] = ~pin_sw_i[5];
      run(1);
    end
    // last toggle was at t=36: 3 edges already elapsed
    run(6);
    check("t3_sw_edge9",  32'(sw_o), 32'h0);
    run(1);
    check("t3_sw_edge10", 32'(sw_o), 32'h0020);
    run(5);
    check("t3_chg_count", 32'(cnt_chg), 32'd1);
    check("t3_sw_end",    32'(sw_o), 32'h0020);

    // 4: button release
    pin_btn_i[2] = 1'b1;
    run(15);
    check("t4_btn_high", 32'(btn_o), 32'h4);
    clear_counts();
    pin_btn_i[2] = 1'b0;
    run(9);
    check("t4_btn_edge9",  32'(btn_o), 32'h4);
    run(1);
    check("t4_btn_edge10", 32'(btn_o), 32'h0);
    run(1);
    check("t4_fall_edge11", 32'(btn_fall_o), 32'h4);
    check("t4_rise_edge11", 32'(btn_rise_o), 32'h0);
    run(5);
    check("t4_fall_count", 32'(cnt_fall[2]), 32'd1);
    check("t4_rise_total", 32'(cnt_rise[0] + cnt_rise[1] + cnt_rise[2] + cnt_rise[3]), 32'd0);

    // 5: simultaneous changes on several channels
    clear_counts();
    pin_sw_i[0]  = 1'b1;
    pin_sw_i[15] = 1'b1;
    pin_btn_i[3] = 1'b1;
    run(9);
    check("t5_sw_edge9",  32'(sw_o), 32'h0020);
    check("t5_btn_edge9", 32'(btn_o), 32'h0);
    run(1);
    check("t5_sw_edge10",  32'(sw_o), 32'h8021);
    check("t5_btn_edge10", 32'(btn_o), 32'h8);
    run(1);
    check("t5_chg_edge11",  32'(sw_chg_o), 32'h1);
    check("t5_rise_edge11", 32'(btn_rise_o), 32'h8);
    check("t5_fall_edge11", 32'(btn_fall_o), 32'h0);
    run(3);
    check("t5_chg_count",  32'(cnt_chg), 32'd1);
    check("t5_rise_count", 32'(cnt_rise[3]), 32'd1);

    // 6: reset arrives mid-count
    reset_to_zero();
    clear_counts();
    pin_sw_i     = 16'h00FF;
    pin_btn_i[1] = 1'b1;
    run(7);
    rst_n = 1'b0;
    #1;
    check_all_zero("t6_in_reset_a");
    run(3);
    check_all_zero("t6_in_reset_b");
    rst_n = 1'b1;
    run(9);
    check("t6_sw_edge9",  32'(sw_o), 32'h0);
    check("t6_btn_edge9", 32'(btn_o), 32'h0);
    run(1);
    check("t6_sw_edge10",  32'(sw_o), 32'h00FF);
    check("t6_btn_edge10", 32'(btn_o), 32'h2);
    run(3);
    check("t6_rise_count", 32'(cnt_rise[1]), 32'd1);
    check("t6_chg_count",  32'(cnt_chg), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
